// File: rtl/btc_cc_decode_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | btc_cc_decode_pkg : shared field offsets, palette codes, states   |
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
package btc_cc_decode_pkg;

  localparam int MIN_HI = 63;
  localparam int MAX_HI = 47;
  localparam int IDX_HI = 31;

  localparam logic [1:0] PAL_MIN  = 2'b00;
  localparam logic [1:0] PAL_MIX1 = 2'b01;
  localparam logic [1:0] PAL_MIX2 = 2'b10;
  localparam logic [1:0] PAL_MAX  = 2'b11;

  localparam int CH_W = 5;
  localparam int R_HI = 14, R_LO = 10;
  localparam int G_HI = 9,  G_LO = 5;
  localparam int B_HI = 4,  B_LO = 0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  // Row 0 lives in the top byte of the index word; pixel k in bits [2k+1:2k].
  function automatic logic [1:0] idx_code(input logic [IDX_HI:0] idx,
                                          input logic [1:0] row,
                                          input int k);
    logic [7:0] row_byte;
    row_byte = 8'(idx >> (8 * (3 - int'(row))));
    return 2'(row_byte >> (2 * k));
  endfunction

endpackage
`default_nettype wire

// File: rtl/btc_cc_lerp.sv
`default_nettype none
// +------------------------------------------------------------------+
// | btc_cc_lerp : combinational 5/8 a + 3/8 b mixer on RGB555        |
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
module btc_cc_lerp
  import btc_cc_decode_pkg::*;
(
  input  logic [14:0] a,
  input  logic [14:0] b,
  output logic [14:0] y
);

  // 5*31 + 3*31 = 248 fits in 8 bits; the >>3 truncates without rounding.
  for (genvar c = 0; c < 3; c++) begin : g_ch
    logic [7:0] sum;
    assign sum = 8'd5 * {3'b000, a[c*CH_W +: CH_W]}
               + 8'd3 * {3'b000, b[c*CH_W +: CH_W]};
    assign y[c*CH_W +: CH_W] = sum[7:3];
  end

endmodule
`default_nettype wire

// File: rtl/btc_cc_decode.sv
`default_nettype none
// +------------------------------------------------------------------+
// | btc_cc_decode : 4x4 color-cell block to row-per-cycle RGB555      |
// | Optional macro JX2_BTCDEC_ALPHA_EN enables punch-through alpha.   |
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
module btc_cc_decode
  import btc_cc_decode_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        inValid,
  output logic        inReady,
  input  logic [63:0] inBlock,
  output logic        outValid,
  input  logic        outReady,
  output logic [63:0] outPix,
  output logic [1:0]  outRow,
  output logic        outLast,
  output logic        busy
);

  state_t      state;
  logic [1:0]  row;
  logic [14:0] pal [4];
  logic [31:0] idx_r;
  logic        punch;

  logic [14:0] blk_min, blk_max, mix1, mix2;
  logic        accept;
  logic        unused_bits;

  assign blk_min = inBlock[MIN_HI-1 -: 15];
  assign blk_max = inBlock[MAX_HI-1 -: 15];
  assign unused_bits = ^{inBlock[MIN_HI], inBlock[MAX_HI]};

  btc_cc_lerp u_mix1 (.a(blk_min), .b(blk_max), .y(mix1));
  btc_cc_lerp u_mix2 (.a(blk_max), .b(blk_min), .y(mix2));

  // Accepting during the final handshaked row keeps back-to-back blocks bubble-free.
  assign inReady = (state == ST_IDLE) || (state == ST_EMIT && row == 2'd3 && outReady);
  assign accept  = inValid && inReady;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      row   <= 2'd0;
      idx_r <= '0;
      punch <= 1'b0;
      for (int i = 0; i < 4; i++) pal[i] <= '0;
    end else begin
      if (accept) begin
        state  <= ST_EMIT;
        row    <= 2'd0;
        idx_r  <= inBlock[IDX_HI:0];
        pal[0] <= blk_min;
        pal[1] <= mix1;
        pal[2] <= mix2;
        pal[3] <= blk_max;
`ifdef JX2_BTCDEC_ALPHA_EN
        punch  <= inBlock[MIN_HI];
`else
        punch  <= 1'b0;
`endif
      end else if (state == ST_EMIT && outReady) begin
        if (row != 2'd3) begin
          row <= row + 2'd1;
        end else begin
          state <= ST_IDLE;
          row   <= 2'd0;
        end
      end
    end
  end

  assign busy     = (state == ST_EMIT);
  assign outValid = busy;
  assign outRow   = row;
  assign outLast  = busy && (row == 2'd3);

  for (genvar k = 0; k < 4; k++) begin : g_pix
    logic [1:0]  code;
    logic [15:0] pix;
    always_comb begin
      code = idx_code(idx_r, row, k);
      pix  = {1'b0, pal[code]};
      if (punch && code == PAL_MIN) pix = 16'h8000;
    end
    assign outPix[16*k +: 16] = busy ? pix : 16'h0000;
  end

endmodule
`default_nettype wire

// File: tb/tb_btc_cc_decode.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_btc_cc_decode : scoreboard bench with random blocks and stalls |
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
module tb_btc_cc_decode;

  logic        clk = 1'b0;
  logic        reset, inValid, inReady, outValid, outReady, outLast, busy;
  logic [63:0] inBlock, outPix;
  logic [1:0]  outRow;

  int          total = 0;
  int          bad   = 0;
  int          rdy_pct = 100;
  bit          mon_en = 0;
  logic [66:0] q[$];

  always #5 clk = ~clk;

  btc_cc_decode dut (
    .clock(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
    .inBlock(inBlock), .outValid(outValid), .outReady(outReady),
    .outPix(outPix), .outRow(outRow), .outLast(outLast), .busy(busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: palette weights straight from the format definition.
  function automatic logic [15:0] ref_pix(input logic [63:0] blk, input int r, input int k);
    int code, a, b, v;
    logic [15:0] p;
    code = int'((blk[31:0] >> (8 * (3 - r) + 2 * k)) & 32'd3);
    p = 16'h0000;
    for (int ch = 0; ch < 3; ch++) begin
      a = int'((blk >> (48 + 5 * ch)) & 64'd31);
      b = int'((blk >> (32 + 5 * ch)) & 64'd31);
      case (code)
        0: v = a;
        1: v = (5 * a + 3 * b) / 8;
        2: v = (3 * a + 5 * b) / 8;
        default: v = b;
      endcase
      p = p | 16'(v << (5 * ch));
    end
`ifdef JX2_BTCDEC_ALPHA_EN
    if (blk[63] && code == 0) p = 16'h8000;
`endif
    return p;
  endfunction

  task automatic push_block(input logic [63:0] blk);
    logic [63:0] row_pix;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) row_pix[16*k +: 16] = ref_pix(blk, r, k);
      q.push_back({(r == 3), 2'(r), row_pix});
    end
  endtask

  task automatic cyc(input logic v, input logic rdy);
    @(negedge clk);
    inValid  = v;
    outReady = rdy;
  endtask

  task automatic send_block(input logic [63:0] blk);
    int n = 0;
    bit acc = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      inValid  = 1'b1;
      inBlock  = blk;
      outReady = ($urandom_range(0, 99) < rdy_pct);
      #1 acc = inReady;
      @(posedge clk);
      if (acc) push_block(blk);
      n++;
    end
    if (!acc) chk("accept_timeout", 64'(acc), 64'd1);
  endtask

  task automatic do_reset_mid();
    @(negedge clk);
    reset    = 1'b1;
    inValid  = 1'b0;
    outReady = 1'b1;
    @(posedge clk);
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    inValid = 1'b0;
    #2;
    chk("rst_outValid", 64'(outValid), 64'd0);
    chk("rst_busy",     64'(busy),     64'd0);
    chk("rst_outPix",   outPix,        64'd0);
    chk("rst_outRow",   64'(outRow),   64'd0);
  endtask

  // Monitor: expected outValid/inReady follow from how many rows are still owed.
  initial begin
    logic [66:0] e;
    bit exp_v;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        exp_v = (q.size() != 0);
        chk("outValid", 64'(outValid), 64'(exp_v));
        chk("busy",     64'(busy),     64'(exp_v));
        chk("inReady",  64'(inReady),
            64'((q.size() == 0) || (q.size() == 1 && outReady)));
        if (exp_v && outValid) begin
          e = q[0];
          chk("outPix",  outPix,        e[63:0]);
          chk("outRow",  64'(outRow),   64'(e[65:64]));
          chk("outLast", 64'(outLast),  64'(e[66]));
          if (outReady) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    int n;
    reset = 1'b1; inValid = 1'b0; inBlock = '0; outReady = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("init_outValid", 64'(outValid), 64'd0);
    chk("init_busy",     64'(busy),     64'd0);
    chk("init_outPix",   outPix,        64'd0);
    chk("init_outRow",   64'(outRow),   64'd0);
    chk("init_outLast",  64'(outLast),  64'd0);
    chk("init_inReady",  64'(inReady),  64'd1);
    @(negedge clk);
    reset = 1'b0;
    mon_en = 1;

    // gradient, then row ordering back-to-back, then the alpha-flag vector
    rdy_pct = 100;
    send_block(64'h0000_7FFF_E4E4E4E4);
    send_block(64'h0000_7FFF_0055AAFF);
    send_block(64'h8000_7FFF_E4E4E4E4);
    repeat (6) cyc(1'b0, 1'b1);

    // stall for three cycles on row 1
    send_block(64'h1234_6B5A_1B2D_C396);
    cyc(1'b0, 1'b1);
    repeat (3) cyc(1'b0, 1'b0);
    repeat (4) cyc(1'b0, 1'b1);

    // reset while row 2 is on the bus, then a fresh block
    send_block(64'h0421_7FFF_E4E4E4E4);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    do_reset_mid();
    send_block(64'h0000_7FFF_E4E4E4E4);
    repeat (6) cyc(1'b0, 1'b1);

    // random blocks with random back-pressure and gaps (Min>Max occurs naturally)
    rdy_pct = 70;
    for (int i = 0; i < 250; i++) begin
      send_block({$urandom, $urandom});
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 5)) cyc(1'b0, 1'($urandom_range(0, 1)));
    end

    n = 0;
    while (q.size() != 0 && n < 200) begin
      cyc(1'b0, 1'b1);
      n++;
    end
    repeat (2) cyc(1'b0, 1'b1);
    chk("drain_rows_left", 64'(q.size()), 64'd0);
    mon_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
